// File: rtl/eth_pcs_pkg.sv
// Shared 64b/66b PCS receive definitions: sync-header codes, block-lock states
// and the header validity check used by the lock controller and eth_rx_interface.
package eth_pcs_pkg;

  localparam logic [1:0] SH_DATA = 2'b01;
  localparam logic [1:0] SH_CTRL = 2'b10;

  typedef enum logic [1:0] {
    RESET_CNT,
    TEST_SH,
    SLIP_WAIT
  } lock_state_e;

  function automatic logic is_valid_sh(input logic [1:0] sh);
    return (sh == SH_DATA) || (sh == SH_CTRL);
  endfunction

endpackage

// File: rtl/eth_ber_monitor.sv
// Sync-header error-rate monitor: counts invalid headers per fixed window of
// clock cycles while block lock is held and flags a high error rate.
module eth_ber_monitor #(
  parameter int BER_WINDOW_CYCLES = 20000,
  parameter int BER_LIMIT         = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic enable,
  input  logic invalid_sample,
  output logic hi_ber
);

  localparam int WIN_W = $clog2(BER_WINDOW_CYCLES + 1);
  localparam int BER_W = $clog2(BER_LIMIT + 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(BER_WINDOW_CYCLES - 1);
  localparam logic [BER_W-1:0] BER_MAX  = BER_W'(BER_LIMIT);

  logic [WIN_W-1:0] win_cnt;
  logic [BER_W-1:0] ber_cnt;
  logic [BER_W-1:0] ber_next;
  logic             hi_ber_q;

  // The error on the window's final cycle still counts toward that window.
  always_comb begin
    ber_next = ber_cnt;
    if (invalid_sample && (ber_cnt != BER_MAX)) ber_next = ber_cnt + 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      win_cnt  <= '0;
      ber_cnt  <= '0;
      hi_ber_q <= 1'b0;
    end else if (!enable) begin
      win_cnt  <= '0;
      ber_cnt  <= '0;
      hi_ber_q <= 1'b0;
    end else if (win_cnt == WIN_LAST) begin
      win_cnt  <= '0;
      ber_cnt  <= '0;
      hi_ber_q <= (ber_next >= BER_MAX);
    end else begin
      win_cnt <= win_cnt + 1'b1;
      ber_cnt <= ber_next;
    end
  end

  // Masked by lock so the flag drops in the same cycle lock is lost.
  assign hi_ber = hi_ber_q & enable;

endmodule

// File: rtl/eth_rx_block_lock.sv
// 64b/66b block-lock controller: slips the gearbox until sync headers align,
// holds lock against a bounded invalid-header count and gates data valid.
module eth_rx_block_lock
  import eth_pcs_pkg::*;
#(
  parameter int SH_CNT_LOCK       = 64,
  parameter int SH_INVALID_MAX    = 16,
  parameter int SLIP_WAIT_CYCLES  = 32,
  parameter int BER_WINDOW_CYCLES = 20000,
  parameter int BER_LIMIT         = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [1:0]  i_header,
  input  logic        i_header_valid,
  input  logic        i_data_valid,
  input  logic        i_clear_counters,
  output logic        o_slip,
  output logic        o_block_lock,
  output logic        o_hi_ber,
  output logic        o_rx_data_valid,
  output logic [15:0] o_slip_count
);

  localparam int SH_W   = $clog2(SH_CNT_LOCK + 1);
  localparam int INV_W  = $clog2(SH_INVALID_MAX + 1);
  localparam int WAIT_W = $clog2(SLIP_WAIT_CYCLES + 1);
  localparam logic [SH_W-1:0]   SH_LAST   = SH_W'(SH_CNT_LOCK);
  localparam logic [INV_W-1:0]  INV_LAST  = INV_W'(SH_INVALID_MAX);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SLIP_WAIT_CYCLES - 1);

  lock_state_e       state, state_next;
  logic [SH_W-1:0]   sh_cnt, sh_cnt_next;
  logic [INV_W-1:0]  sh_invalid_cnt, sh_invalid_cnt_next;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_next;
  logic              lock_next;
  logic              slip_next;
  logic [15:0]       slip_count_next;
  logic              sample;
  logic              sample_invalid;

  assign sample         = i_data_valid & i_header_valid;
  assign sample_invalid = sample & ~is_valid_sh(i_header);

  always_comb begin
    state_next          = state;
    sh_cnt_next         = sh_cnt;
    sh_invalid_cnt_next = sh_invalid_cnt;
    wait_cnt_next       = wait_cnt;
    lock_next           = o_block_lock;
    slip_next           = 1'b0;
    case (state)
      RESET_CNT: begin
        sh_cnt_next         = '0;
        sh_invalid_cnt_next = '0;
        wait_cnt_next       = '0;
        state_next          = TEST_SH;
      end
      TEST_SH: begin
        if (sample) begin
          sh_cnt_next = sh_cnt + 1'b1;
          if (sample_invalid) sh_invalid_cnt_next = sh_invalid_cnt + 1'b1;
          // Slip/unlock is checked first so it beats a completing window.
          if (!o_block_lock && sample_invalid) begin
            slip_next     = 1'b1;
            wait_cnt_next = '0;
            state_next    = SLIP_WAIT;
          end else if (o_block_lock && (sh_invalid_cnt_next == INV_LAST)) begin
            lock_next     = 1'b0;
            slip_next     = 1'b1;
            wait_cnt_next = '0;
            state_next    = SLIP_WAIT;
          end else if (sh_cnt_next == SH_LAST) begin
            lock_next  = 1'b1;
            state_next = RESET_CNT;
          end
        end
      end
      SLIP_WAIT: begin
        if (wait_cnt == WAIT_LAST) begin
          wait_cnt_next = '0;
          state_next    = RESET_CNT;
        end else begin
          wait_cnt_next = wait_cnt + 1'b1;
        end
      end
      default: state_next = RESET_CNT;
    endcase
  end

  always_comb begin
    slip_count_next = o_slip_count;
    if (i_clear_counters)                        slip_count_next = '0;
    else if (slip_next && (o_slip_count != 16'hFFFF)) slip_count_next = o_slip_count + 16'd1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state          <= RESET_CNT;
      sh_cnt         <= '0;
      sh_invalid_cnt <= '0;
      wait_cnt       <= '0;
      o_block_lock   <= 1'b0;
      o_slip         <= 1'b0;
      o_slip_count   <= '0;
    end else begin
      state          <= state_next;
      sh_cnt         <= sh_cnt_next;
      sh_invalid_cnt <= sh_invalid_cnt_next;
      wait_cnt       <= wait_cnt_next;
      o_block_lock   <= lock_next;
      o_slip         <= slip_next;
      o_slip_count   <= slip_count_next;
    end
  end

  // Combinational so the strobe stays aligned with the data beat.
  assign o_rx_data_valid = i_data_valid & o_block_lock;

  eth_ber_monitor #(
    .BER_WINDOW_CYCLES (BER_WINDOW_CYCLES),
    .BER_LIMIT         (BER_LIMIT)
  ) u_ber_monitor (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .enable         (o_block_lock),
    .invalid_sample (sample_invalid),
    .hi_ber         (o_hi_ber)
  );

endmodule
